// File: rtl/sine_meas.sv
// sine_meas: peak / peak-to-peak / period measurement on the sine FIR output.
// Uses rising zero crossings with a negative hysteresis arm to span NCYC
// full periods. Results are held until the next measurement or reset.
module sine_meas #(
   parameter int NCYC  = 8,
   parameter int HYST  = 1024,
   parameter int TO_W  = 20,
   parameter int CNT_W = 24
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [17:0]      y_in,
   input  logic                    start,
   output logic                    busy,
   output logic                    meas_valid,
   output logic                    timeout,
   output logic signed [17:0]      peak_pos,
   output logic signed [17:0]      peak_neg,
   output logic signed [18:0]      amp_pp,
   output logic [CNT_W-1:0]        cycles_sum
);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   localparam int                 XC_W     = $clog2(NCYC + 1);
   localparam logic signed [17:0] NEG_HYST = 18'(-HYST);

   // Widened subtraction so full-scale extremes cannot wrap
   function automatic logic signed [18:0] pp_diff(input logic signed [17:0] hi,
                                                  input logic signed [17:0] lo);
      return {hi[17], hi} - {lo[17], lo};
   endfunction

   // Counter increment that sticks at all-ones
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic signed [17:0] smax(input logic signed [17:0] a,
                                               input logic signed [17:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic signed [17:0] smin(input logic signed [17:0] a,
                                               input logic signed [17:0] b);
      return (a < b) ? a : b;
   endfunction

   state_t                   state_q;
   logic signed [17:0]       y_q;
   logic                     arm_q;
   logic [TO_W-1:0]          to_q;
   logic [TO_W-1:0]          to_d;
   logic [CNT_W-1:0]         cyc_q;
   logic [CNT_W-1:0]         cyc_d;
   logic [XC_W-1:0]          xcnt_q;
   logic signed [17:0]       trk_pos_q, trk_neg_q;
   logic signed [17:0]       trk_pos_d, trk_neg_d;
   logic                     mv_q, tout_q;
   logic signed [17:0]       res_pos_q, res_neg_q;
   logic signed [18:0]       res_amp_q;
   logic [CNT_W-1:0]         res_cyc_q;
   logic                     crossing, to_hit, last_x, below;

   assign busy       = (state_q != IDLE);
   assign meas_valid = mv_q;
   assign timeout    = tout_q;
   assign peak_pos   = res_pos_q;
   assign peak_neg   = res_neg_q;
   assign amp_pp     = res_amp_q;
   assign cycles_sum = res_cyc_q;

   assign below     = (y_q < NEG_HYST);
   assign crossing  = busy && arm_q && !y_q[17];
   assign to_d      = to_q + TO_W'(1);
   assign to_hit    = (to_d == {TO_W{1'b1}});
   assign cyc_d     = sat_inc(cyc_q);
   assign last_x    = (xcnt_q == XC_W'(NCYC - 1));
   assign trk_pos_d = smax(trk_pos_q, y_q);
   assign trk_neg_d = smin(trk_neg_q, y_q);

   // Register the filter output; all detection runs on y_q
   always_ff @(posedge clk) begin
      y_q <= y_in;
   end

   // Peak trackers: seeded on the first crossing, then follow y_q while measuring
   always_ff @(posedge clk) begin
      if (state_q == ARM && crossing) begin
         trk_pos_q <= y_q;
         trk_neg_q <= y_q;
      end else if (state_q == MEASURE) begin
         trk_pos_q <= trk_pos_d;
         trk_neg_q <= trk_neg_d;
      end
   end

   // Measurement FSM with arm flag, timeout, counters and held results
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         arm_q     <= 1'b0;
         to_q      <= '0;
         cyc_q     <= '0;
         xcnt_q    <= '0;
         mv_q      <= 1'b0;
         tout_q    <= 1'b0;
         res_pos_q <= '0;
         res_neg_q <= '0;
         res_amp_q <= '0;
         res_cyc_q <= '0;
      end else begin
         mv_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // a start coinciding with the result pulse is dropped
               if (start && !mv_q) begin
                  state_q <= ARM;
                  arm_q   <= 1'b0;
                  to_q    <= '0;
               end
            end
            ARM: begin
               if (crossing) begin
                  state_q <= MEASURE;
                  arm_q   <= 1'b0;
                  to_q    <= '0;
                  cyc_q   <= '0;
                  xcnt_q  <= '0;
               end else begin
                  if (below) arm_q <= 1'b1;
                  if (to_hit) begin
                     state_q   <= IDLE;
                     mv_q      <= 1'b1;
                     tout_q    <= 1'b1;
                     res_pos_q <= '0;
                     res_neg_q <= '0;
                     res_amp_q <= '0;
                     res_cyc_q <= '0;
                  end else begin
                     to_q <= to_d;
                  end
               end
            end
            MEASURE: begin
               cyc_q <= cyc_d;
               if (crossing) begin
                  arm_q  <= 1'b0;
                  to_q   <= '0;
                  xcnt_q <= xcnt_q + XC_W'(1);
                  if (last_x) begin
                     // cyc_q lags the crossing distance by one, hence cyc_d
                     state_q   <= IDLE;
                     mv_q      <= 1'b1;
                     tout_q    <= 1'b0;
                     res_pos_q <= trk_pos_d;
                     res_neg_q <= trk_neg_d;
                     res_amp_q <= pp_diff(trk_pos_d, trk_neg_d);
                     res_cyc_q <= cyc_d;
                  end
               end else begin
                  if (below) arm_q <= 1'b1;
                  if (to_hit) begin
                     state_q   <= IDLE;
                     mv_q      <= 1'b1;
                     tout_q    <= 1'b1;
                     res_pos_q <= trk_pos_d;
                     res_neg_q <= trk_neg_d;
                     res_amp_q <= pp_diff(trk_pos_d, trk_neg_d);
                     res_cyc_q <= '0;
                  end else begin
                     to_q <= to_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sine_meas.sv
// Directed bench for sine_meas: square, zero-level, timeout, chatter,
// reset abort, start spam and full-scale cases with hand-derived results.
module tb_sine_meas;

   localparam int NCYC  = 8;
   localparam int HYST  = 1024;
   localparam int TO_W  = 8;
   localparam int CNT_W = 24;
   localparam int NONE  = 100000;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    start = 1'b0;
   logic signed [17:0]      y_in = '0;
   logic                    busy, meas_valid, timeout;
   logic signed [17:0]      peak_pos, peak_neg;
   logic signed [18:0]      amp_pp;
   logic [CNT_W-1:0]        cycles_sum;

   int cyc = 0;
   int mv_cnt = 0;
   int mv_cyc = 0;
   int c0 = 0;
   int m0 = 0;
   int npass = 0;
   int nchk = 0;

   sine_meas #(.NCYC(NCYC), .HYST(HYST), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .y_in(y_in), .start(start),
      .busy(busy), .meas_valid(meas_valid), .timeout(timeout),
      .peak_pos(peak_pos), .peak_neg(peak_neg), .amp_pp(amp_pp),
      .cycles_sum(cycles_sum)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (meas_valid) begin
         mv_cnt <= mv_cnt + 1;
         mv_cyc <= cyc;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input longint obs, input longint exp);
      nchk++;
      assert (obs === exp) begin
         npass++;
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int v, input logic st, input logic rs);
      y_in  = 18'(v);
      start = st;
      reset = rs;
      @(posedge clk);
      #1;
   endtask

   // Square wave: lo for half samples then hi for half, nper periods
   task automatic sq(input int lo, input int hi, input int half, input int nper,
                     input int start_n, input int spam_n, input int rst_n);
      for (int n = 0; n < 2 * half * nper; n++) begin
         int  ph;
         logic st, rs;
         ph = n % (2 * half);
         st = (n == start_n) || (n >= spam_n && n < spam_n + 4);
         rs = (n >= rst_n && n < rst_n + 2);
         tick((ph < half) ? lo : hi, st, rs);
         if (n == start_n) c0 = cyc;
      end
      start = 1'b0;
      reset = 1'b0;
   endtask

   task automatic expect_meas(input string tg, input int lat, input int pos,
                              input int neg, input int amp, input int cs,
                              input int to);
      check({tg, ".mv_count"}, mv_cnt - m0, 1);
      check({tg, ".latency"},  mv_cyc - c0, lat);
      check({tg, ".peak_pos"}, $signed(peak_pos), pos);
      check({tg, ".peak_neg"}, $signed(peak_neg), neg);
      check({tg, ".amp_pp"},   $signed(amp_pp), amp);
      check({tg, ".cycles"},   cycles_sum, cs);
      check({tg, ".timeout"},  timeout, to);
      check({tg, ".busy"},     busy, 0);
   endtask

   initial begin
      // reset
      for (int i = 0; i < 3; i++) tick(0, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) tick(0, 1'b0, 1'b0);
      check("rst.busy", busy, 0);
      check("rst.mv", meas_valid, 0);
      check("rst.timeout", timeout, 0);
      check("rst.peak_pos", $signed(peak_pos), 0);
      check("rst.peak_neg", $signed(peak_neg), 0);
      check("rst.amp_pp", $signed(amp_pp), 0);
      check("rst.cycles", cycles_sum, 0);

      // square +-2000, period 100
      m0 = mv_cnt;
      sq(-2000, 2000, 50, 11, 0, NONE, NONE);
      expect_meas("square", 851, 2000, -2000, 4000, 800, 0);

      // high level exactly 0 counts as non-negative
      m0 = mv_cnt;
      sq(-2000, 0, 50, 11, 0, NONE, NONE);
      expect_meas("zero_hi", 851, 0, -2000, 2000, 800, 0);

      // constant +500: never arms, times out from ARM
      m0 = mv_cnt;
      for (int n = 0; n < 300; n++) begin
         tick(500, n == 0, 1'b0);
         if (n == 0) c0 = cyc;
         if (n == 100) check("to_arm.busy_mid", busy, 1);
      end
      start = 1'b0;
      expect_meas("to_arm", 255, 0, 0, 0, 0, 1);

      // two periods then flat: times out from MEASURE with partial peaks
      m0 = mv_cnt;
      sq(-3000, 3000, 20, 2, 0, NONE, NONE);
      for (int n = 0; n < 300; n++) tick(500, 1'b0, 1'b0);
      expect_meas("to_meas", 316, 3000, -3000, 6000, 0, 1);

      // chatter between +800 and -1024 (exactly -HYST), then clean +-5000 period 40
      m0 = mv_cnt;
      for (int n = 0; n < 60; n++) begin
         tick((n % 2 == 1) ? -1024 : 800, n == 0, 1'b0);
         if (n == 0) c0 = cyc;
      end
      start = 1'b0;
      sq(-5000, 5000, 20, 10, NONE, NONE, NONE);
      expect_meas("chatter", 401, 5000, -5000, 10000, 320, 0);

      // reset in the middle of MEASURE: aborts silently, clears results
      m0 = mv_cnt;
      sq(-2000, 2000, 50, 3, 0, NONE, 200);
      check("rstmid.mv_count", mv_cnt - m0, 0);
      check("rstmid.busy", busy, 0);
      check("rstmid.timeout", timeout, 0);
      check("rstmid.peak_pos", $signed(peak_pos), 0);
      check("rstmid.peak_neg", $signed(peak_neg), 0);
      check("rstmid.amp_pp", $signed(amp_pp), 0);
      check("rstmid.cycles", cycles_sum, 0);

      // start pulses while busy are ignored
      m0 = mv_cnt;
      sq(-2000, 2000, 50, 11, 0, 300, NONE);
      expect_meas("spam", 851, 2000, -2000, 4000, 800, 0);

      // full-scale alternation, period 10
      m0 = mv_cnt;
      sq(-131072, 131071, 5, 11, 0, NONE, NONE);
      expect_meas("fullscale", 86, 131071, -131072, 262143, 80, 0);

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
